camera_init_seq: RTL and testbench
==================================

Name: camera_init_seq

Overview:
Parametrised camera-register init sequencer. Walks an external {REG, VALUE} init table by index and issues one register write per entry to the SCCB master over a valid/ready + done/nack handshake. Interprets in-table delay and end markers and reports busy/done/error status to the top-level control FSM. Sits between the init-table ROM and the SCCB master.

Parameters:
IDX_W, 8, table index width; max table depth 2^IDX_W entries
REG_W, 8, register address field width
VAL_W, 8, register value field width
ROM_LAT, 1, table read latency in cycles (1 or 2)
DELAY_UNIT, 24000, clock cycles per delay-marker count (1 ms at 24 MHz)
MAX_RETRY, 3, write retries on NACK (used only with the optional feature)

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  asynchronous active-low reset
i_Start  in  1  single-cycle start pulse
o_Rom_Addr  out  IDX_W  table index
i_Rom_Data  in  REG_W+VAL_W  table entry {REG, VALUE}; valid ROM_LAT cycles after o_Rom_Addr
o_Wr_Valid  out  1  write request valid
i_Wr_Ready  in  1  SCCB master accepts request
o_Wr_Reg  out  REG_W  register address
o_Wr_Val  out  VAL_W  register value
i_Wr_Done  in  1  one-cycle pulse, write transaction finished
i_Wr_Nack  in  1  qualifies i_Wr_Done: slave NACKed
o_Busy  out  1  sequence running
o_Done  out  1  sequence completed (sticky)
o_Err  out  1  sequence aborted on NACK (sticky)
o_Count  out  IDX_W+1  number of successfully acked writes

Behaviour:
- Reset (async, i_Rst=0): all outputs 0, state IDLE, index 0; reset mid-sequence drops o_Wr_Valid immediately.
- States: IDLE, FETCH, DECODE, REQ, WAIT_ACK, DELAY, DONE, ERROR.
- IDLE/DONE/ERROR + i_Start: index<=0, o_Count<=0, o_Done<=0, o_Err<=0, o_Busy<=1, go FETCH. i_Start ignored in every other state.
- FETCH: drive o_Rom_Addr=index; wait ROM_LAT cycles; go DECODE.
- DECODE, entry classification:
  - REG=all-ones and VALUE=all-ones: end marker; go DONE.
  - REG=all-ones and VALUE≠all-ones: delay of VALUE*DELAY_UNIT cycles; go DELAY (VALUE=0: advance directly).
  - Otherwise: latch o_Wr_Reg/o_Wr_Val; go REQ.
- REQ: o_Wr_Valid=1, with o_Wr_Reg/o_Wr_Val held stable. Handshake completes in a cycle where i_Wr_Ready=1; o_Wr_Valid drops the next cycle. Go WAIT_ACK.
- WAIT_ACK on i_Wr_Done:
  - i_Wr_Nack=0: o_Count++, advance.
  - i_Wr_Nack=1: go ERROR.
  - i_Wr_Done while not in WAIT_ACK is ignored.
- DELAY: counter width covers VAL_W + clog2(DELAY_UNIT). Exactly VALUE*DELAY_UNIT cycles elapse in DELAY, then advance.
- Advance: if index = 2^IDX_W−1, go DONE (no wrap); else index++, go FETCH.
- DONE: o_Busy=0, o_Done=1. ERROR: o_Busy=0, o_Err=1; o_Rom_Addr holds the failing index.
- Throughput: one write per FETCH+DECODE+REQ+WAIT_ACK, i.e. ROM_LAT+2 cycles of overhead plus SCCB time.

Optional Feature:
CAMSEQ_RETRY_EN
- Defined: on NACK, reissue the same entry (back to REQ) up to MAX_RETRY times. The retry counter clears on each new entry. Go ERROR only after the (MAX_RETRY+1)th consecutive NACK.
- Undefined: the first NACK goes ERROR; no retry counter is synthesised.

Test Plan:
- Table {12_80, 12_04, FF_FF}, ready/done immediate, no nack -> writes (12,80),(12,04) in order; o_Done=1, o_Count=2, o_Busy falls same cycle o_Done rises.
- Table {FF_02, 11_00, FF_FF}, DELAY_UNIT=10 -> first o_Wr_Valid exactly 20 cycles after DELAY entry plus fetch overhead; entry FF_00 adds no delay.
- i_Wr_Ready held low 5 cycles -> o_Wr_Valid/o_Wr_Reg/o_Wr_Val stable all 5 cycles; single write counted.
- NACK on entry 1: without macro -> o_Err=1, o_Rom_Addr=1, o_Count=1. With macro and MAX_RETRY=3, NACK three times then ACK -> 4 requests for entry 1, o_Done=1. Four NACKs -> o_Err=1.
- Table with no end marker, IDX_W=3 -> 8 writes, o_Done=1, o_Rom_Addr never wraps to 0 mid-run.
- i_Rst asserted while in REQ -> o_Wr_Valid=0 asynchronously, all status 0; i_Start pulse during Busy ignored; new i_Start after reset restarts at index 0.

Source files
------------

// File: rtl/camera_init_seq.sv
// camera_init_seq: walks a {REG,VALUE} init table, one SCCB write per entry.
// Optional NACK retry is compiled in when CAMSEQ_RETRY_EN is defined.
module camera_init_seq #(
  parameter int IDX_W      = 8,
  parameter int REG_W      = 8,
  parameter int VAL_W      = 8,
  parameter int ROM_LAT    = 1,
  parameter int DELAY_UNIT = 24000,
  parameter int MAX_RETRY  = 3
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Start,
  output logic [IDX_W-1:0]       o_Rom_Addr,
  input  logic [REG_W+VAL_W-1:0] i_Rom_Data,
  output logic                   o_Wr_Valid,
  input  logic                   i_Wr_Ready,
  output logic [REG_W-1:0]       o_Wr_Reg,
  output logic [VAL_W-1:0]       o_Wr_Val,
  input  logic                   i_Wr_Done,
  input  logic                   i_Wr_Nack,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Err,
  output logic [IDX_W:0]         o_Count
);

  localparam int DLY_W = VAL_W + $clog2(DELAY_UNIT);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, REQ, WAIT_ACK, DELAY, DONE, ERROR
  } state_t;

  state_t state, next;

  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   count;
  logic [1:0]       lat_cnt;
  logic [DLY_W-1:0] dly_cnt;
  logic [REG_W-1:0] wr_reg;
  logic [VAL_W-1:0] wr_val;

  logic [REG_W-1:0] ent_reg;
  logic [VAL_W-1:0] ent_val;
  logic reg_ones, val_ones, val_zero;
  logic last, lat_hit, dly_hit;
  logic ack, nack, idle_like, start, adv;
  logic retry_left;

  assign ent_reg  = i_Rom_Data[REG_W+VAL_W-1:VAL_W];
  assign ent_val  = i_Rom_Data[VAL_W-1:0];
  assign reg_ones = &ent_reg;
  assign val_ones = &ent_val;
  assign val_zero = ent_val == '0;
  assign last     = &idx;
  assign lat_hit  = lat_cnt == 2'(ROM_LAT - 1);
  assign dly_hit  = dly_cnt == '0;
  assign ack      = i_Wr_Done & ~i_Wr_Nack;
  assign nack     = i_Wr_Done & i_Wr_Nack;

  assign idle_like = (state == IDLE) || (state == DONE) ||
                     (state == ERROR);
  assign start     = idle_like && i_Start;
  assign adv       = !idle_like && (state != FETCH) && (next == FETCH);

`ifdef CAMSEQ_RETRY_EN
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  logic [RTY_W-1:0] retry;

  assign retry_left = retry != RTY_W'(MAX_RETRY);

  // retry count per entry, cleared whenever a new entry is decoded
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      retry <= '0;
    end else if (state == DECODE) begin
      retry <= '0;
    end else if (state == WAIT_ACK && nack && retry_left) begin
      retry <= retry + RTY_W'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = MAX_RETRY > 0;
  assign retry_left = 1'b0;
`endif

  // state register
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) state <= IDLE;
    else        state <= next;
  end

  // next-state decode
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (i_Start) next = FETCH;
      end
      FETCH: begin
        if (lat_hit) next = DECODE;
      end
      DECODE: begin
        if (reg_ones && val_ones) next = DONE;
        else if (reg_ones && val_zero) next = last ? DONE : FETCH;
        else if (reg_ones) next = DELAY;
        else next = REQ;
      end
      REQ: begin
        if (i_Wr_Ready) next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack) next = last ? DONE : FETCH;
        else if (nack) next = retry_left ? REQ : ERROR;
      end
      DELAY: begin
        if (dly_hit) next = last ? DONE : FETCH;
      end
      default: next = IDLE;
    endcase
  end

  // index, write count, latency/delay counters and latched entry
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      idx     <= '0;
      count   <= '0;
      lat_cnt <= '0;
      dly_cnt <= '0;
      wr_reg  <= '0;
      wr_val  <= '0;
    end else begin
      if (start) idx <= '0;
      else if (adv) idx <= idx + IDX_W'(1);

      if (start) count <= '0;
      else if (state == WAIT_ACK && ack) count <= count + (IDX_W+1)'(1);

      if (state == FETCH) lat_cnt <= lat_cnt + 2'd1;
      else lat_cnt <= '0;

      if (state == DECODE)
        dly_cnt <= DLY_W'(ent_val) * DLY_W'(DELAY_UNIT) - DLY_W'(1);
      else if (state == DELAY)
        dly_cnt <= dly_cnt - DLY_W'(1);

      if (state == DECODE && next == REQ) begin
        wr_reg <= ent_reg;
        wr_val <= ent_val;
      end
    end
  end

  // status and handshake outputs follow the state directly
  always_comb begin
    o_Wr_Valid = state == REQ;
    o_Busy     = !idle_like;
    o_Done     = state == DONE;
    o_Err      = state == ERROR;
    o_Rom_Addr = idx;
    o_Count    = count;
    o_Wr_Reg   = wr_reg;
    o_Wr_Val   = wr_val;
  end

endmodule

// File: tb/tb_camera_init_seq.sv
// tb_camera_init_seq: directed bench with a write scoreboard and an SCCB
// responder model; the retry steps follow CAMSEQ_RETRY_EN.
module tb_camera_init_seq;

  localparam int IDX_W = 3;
  localparam int REG_W = 8;
  localparam int VAL_W = 8;
  localparam int ROM_LAT = 1;
  localparam int DELAY_UNIT = 10;
  localparam int MAX_RETRY = 3;

  logic clk = 1'b0;
  logic rst_n, start;
  logic [IDX_W-1:0] rom_addr;
  logic [15:0] rom_data;
  logic wr_valid, wr_ready;
  logic [7:0] wr_reg, wr_val;
  logic wr_done, wr_nack;
  logic busy, done, err;
  logic [IDX_W:0] count;

  logic [15:0] rom [8];
  logic [15:0] exp_q [$];
  bit nack_plan [$];

  int checks = 0;
  int errors = 0;
  int ready_lat = 0;
  bit resp_en = 1'b0;
  int n_req = 0;
  int stall = 0;
  logic [15:0] held;
  bit fin, wrapped;
  int cyc;
  bit seen;

  camera_init_seq #(
    .IDX_W(IDX_W), .REG_W(REG_W), .VAL_W(VAL_W),
    .ROM_LAT(ROM_LAT), .DELAY_UNIT(DELAY_UNIT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst_n),
    .i_Start(start),
    .o_Rom_Addr(rom_addr),
    .i_Rom_Data(rom_data),
    .o_Wr_Valid(wr_valid),
    .i_Wr_Ready(wr_ready),
    .o_Wr_Reg(wr_reg),
    .o_Wr_Val(wr_val),
    .i_Wr_Done(wr_done),
    .i_Wr_Nack(wr_nack),
    .o_Busy(busy),
    .o_Done(done),
    .o_Err(err),
    .o_Count(count)
  );

  always #5 clk = ~clk;

  // one-cycle registered table ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SCCB responder: stalls ready, scoreboards accepted writes, answers done
  initial begin
    wr_ready = 1'b0;
    wr_done = 1'b0;
    wr_nack = 1'b0;
    forever begin
      @(negedge clk);
      wr_done = 1'b0;
      wr_nack = 1'b0;
      if (!resp_en) begin
        wr_ready = 1'b0;
        stall = 0;
      end else if (wr_ready) begin
        wr_ready = 1'b0;
        stall = 0;
        n_req++;
        wr_done = 1'b1;
        if (nack_plan.size() > 0) wr_nack = nack_plan.pop_front();
      end else if (wr_valid) begin
        if (stall == 0) held = {wr_reg, wr_val};
        else check("stall_hold", {15'd0, wr_valid, wr_reg, wr_val},
                   {15'd0, 1'b1, held});
        stall++;
        if (stall > ready_lat) begin
          wr_ready = 1'b1;
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow observed=%0h expected=none",
                   {wr_reg, wr_val});
          end
          if (exp_q.size() != 0)
            check("sb_write", {16'd0, wr_reg, wr_val},
                  {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // run until busy drops; poke >= 0 re-pulses start mid-run
  task automatic run(string tag, int budget, int poke);
    logic [IDX_W-1:0] prev;
    prev = rom_addr;
    fin = 1'b0;
    wrapped = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
      start = (i == poke);
      if (rom_addr < prev) wrapped = 1'b1;
      prev = rom_addr;
    end
    start = 1'b0;
    check({tag, "_finished"}, {31'd0, fin}, 32'd1);
  endtask

  task automatic load(logic [15:0] e0, logic [15:0] e1,
                      logic [15:0] e2, logic [15:0] e3);
    rom[0] = e0;
    rom[1] = e1;
    rom[2] = e2;
    rom[3] = e3;
    for (int i = 4; i < 8; i++) rom[i] = 16'hFFFF;
    exp_q.delete();
    nack_plan.delete();
    n_req = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_addr", {29'd0, rom_addr}, 32'd0);
    rst_n = 1'b1;
    resp_en = 1'b1;

    // two plain writes then end marker
    load(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1204);
    pulse_start();
    run("t1", 200, -1);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_count", {28'd0, count}, 32'd2);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_reqs", n_req, 32'd2);
    check("t1_sb_left", exp_q.size(), 32'd0);

    // delay marker of 2 units before the write
    load(16'hFF02, 16'h1100, 16'hFFFF, 16'hFFFF);
    exp_q.push_back(16'h1100);
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (wr_valid) seen = 1'b1;
    end
    check("t2_first_valid_cycle", cyc, 32'd25);
    run("t2", 200, -1);
    check("t2_count", {28'd0, count}, 32'd1);
    check("t2_done", {31'd0, done}, 32'd1);

    // zero-length delay marker adds nothing
    load(16'hFF00, 16'h1100, 16'hFFFF, 16'hFFFF);
    exp_q.push_back(16'h1100);
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (wr_valid) seen = 1'b1;
    end
    check("t2b_first_valid_cycle", cyc, 32'd5);
    run("t2b", 200, -1);
    check("t2b_count", {28'd0, count}, 32'd1);

    // ready held low while the request must stay stable
    load(16'h3A55, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    exp_q.push_back(16'h3A55);
    ready_lat = 5;
    pulse_start();
    run("t3", 200, -1);
    ready_lat = 0;
    check("t3_count", {28'd0, count}, 32'd1);
    check("t3_reqs", n_req, 32'd1);
    check("t3_done", {31'd0, done}, 32'd1);

`ifdef CAMSEQ_RETRY_EN
    // three NACKs then ACK on entry 1 recovers
    load(16'h1280, 16'h1301, 16'h1402, 16'hFFFF);
    exp_q.push_back(16'h1280);
    repeat (4) exp_q.push_back(16'h1301);
    exp_q.push_back(16'h1402);
    nack_plan.push_back(1'b0);
    repeat (3) nack_plan.push_back(1'b1);
    pulse_start();
    run("t4r", 300, -1);
    check("t4r_done", {31'd0, done}, 32'd1);
    check("t4r_err", {31'd0, err}, 32'd0);
    check("t4r_count", {28'd0, count}, 32'd3);
    check("t4r_reqs", n_req, 32'd6);
    check("t4r_sb_left", exp_q.size(), 32'd0);

    // four NACKs on entry 1 abort
    load(16'h1280, 16'h1301, 16'h1402, 16'hFFFF);
    exp_q.push_back(16'h1280);
    repeat (4) exp_q.push_back(16'h1301);
    nack_plan.push_back(1'b0);
    repeat (4) nack_plan.push_back(1'b1);
    pulse_start();
    run("t4e", 300, -1);
    check("t4e_err", {31'd0, err}, 32'd1);
    check("t4e_addr", {29'd0, rom_addr}, 32'd1);
    check("t4e_count", {28'd0, count}, 32'd1);
    check("t4e_reqs", n_req, 32'd5);
`else
    // first NACK on entry 1 aborts
    load(16'h1280, 16'h1301, 16'h1402, 16'hFFFF);
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1301);
    nack_plan.push_back(1'b0);
    nack_plan.push_back(1'b1);
    pulse_start();
    run("t4", 300, -1);
    check("t4_err", {31'd0, err}, 32'd1);
    check("t4_done", {31'd0, done}, 32'd0);
    check("t4_addr", {29'd0, rom_addr}, 32'd1);
    check("t4_count", {28'd0, count}, 32'd1);
    check("t4_reqs", n_req, 32'd2);
    check("t4_sb_left", exp_q.size(), 32'd0);
`endif

    // full table without end marker; start pulse mid-run ignored
    load(16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      rom[i] = {8'h20 + 8'(i), 8'(i * 16)};
      exp_q.push_back(rom[i]);
    end
    pulse_start();
    run("t5", 400, 15);
    check("t5_wrapped", {31'd0, wrapped}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_count", {28'd0, count}, 32'd8);
    check("t5_addr", {29'd0, rom_addr}, 32'd7);
    check("t5_reqs", n_req, 32'd8);
    check("t5_sb_left", exp_q.size(), 32'd0);

    // async reset while entry 1 is in REQ
    load(16'h1111, 16'h1280, 16'hFFFF, 16'hFFFF);
    exp_q.push_back(16'h1111);
    ready_lat = 3;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (wr_valid && rom_addr == 3'd1) seen = 1'b1;
    end
    check("t6_req_seen", {31'd0, seen}, 32'd1);
    check("t6_count_before", {28'd0, count}, 32'd1);
    #2;
    rst_n = 1'b0;
    resp_en = 1'b0;
    #1;
    check("t6_valid", {31'd0, wr_valid}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_count", {28'd0, count}, 32'd0);
    check("t6_addr", {29'd0, rom_addr}, 32'd0);
    check("t6_reg", {24'd0, wr_reg}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_lat = 0;
    @(negedge clk);
    resp_en = 1'b1;
    load(16'h4321, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    exp_q.push_back(16'h4321);
    pulse_start();
    run("t6r", 200, -1);
    check("t6r_done", {31'd0, done}, 32'd1);
    check("t6r_count", {28'd0, count}, 32'd1);
    check("t6r_sb_left", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
